// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the pipeline control blocks.
// Holds the hazard FSM state encoding and the hard-wired zero register id.
package riscv_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MC_BUSY = 2'b01,
    FLUSH   = 2'b10
  } hazard_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline <-> hazard unit bundle (ID/EX status in, controls out).
// master = pipeline side, slave = hazard unit side.
interface hazard_unit_if;

  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_uses_rs1_i;
  logic       id_uses_rs2_i;
  logic       ex_mem_read_i;
  logic [4:0] ex_rd_i;
  logic       ex_branch_taken_i;
  logic       ex_mc_start_i;
  logic       ex_mc_done_i;
  logic       pc_stall_o;
  logic       if_id_stall_o;
  logic       id_ex_bubble_o;
  logic       if_id_flush_o;
  logic       id_ex_flush_o;
  logic       ex_stall_o;
  logic [1:0] state_o;

  modport master (
    output id_rs1_i, id_rs2_i,
    output id_uses_rs1_i, id_uses_rs2_i,
    output ex_mem_read_i, ex_rd_i,
    output ex_branch_taken_i,
    output ex_mc_start_i, ex_mc_done_i,
    input  pc_stall_o, if_id_stall_o,
    input  id_ex_bubble_o,
    input  if_id_flush_o, id_ex_flush_o,
    input  ex_stall_o, state_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i,
    input  id_uses_rs1_i, id_uses_rs2_i,
    input  ex_mem_read_i, ex_rd_i,
    input  ex_branch_taken_i,
    input  ex_mc_start_i, ex_mc_done_i,
    output pc_stall_o, if_id_stall_o,
    output id_ex_bubble_o,
    output if_id_flush_o, id_ex_flush_o,
    output ex_stall_o, state_o
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: 32-bit saturating event counter with synchronous clear.
// Ports: clk_i, clear_i (sync), en_i (count this cycle), count_o.
module hazard_perf_cnt (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, branch flush and multicycle-EX stall control.
// Ports: clk_i, rst_ni (sync, low), hz (slave); stall_cycles_o if HAZARD_PERF_CNT_EN.
module hazard_unit
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  hazard_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);

  hazard_state_t state_q;
  hazard_state_t state_d;

  logic load_use;
  logic pc_stall;
  logic if_id_stall;
  logic bubble;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_stall;

  always_comb begin
    load_use = 1'b0;
    if (hz.ex_mem_read_i && (hz.ex_rd_i != REG_ZERO)) begin
      load_use =
        (hz.id_uses_rs1_i && (hz.ex_rd_i == hz.id_rs1_i)) ||
        (hz.id_uses_rs2_i && (hz.ex_rd_i == hz.id_rs2_i));
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    bubble      = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // branch beats multicycle start beats load-use
        if (hz.ex_branch_taken_i) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = FLUSH;
        end else if (hz.ex_mc_start_i && !hz.ex_mc_done_i) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          ex_stall    = 1'b1;
          state_d     = MC_BUSY;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          bubble      = 1'b1;
        end
      end
      MC_BUSY: begin
        if (hz.ex_mc_done_i) begin
          state_d = IDLE;
        end else begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          ex_stall    = 1'b1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // outputs are forced low while reset is held, whatever the state
  assign hz.pc_stall_o     = rst_ni & pc_stall;
  assign hz.if_id_stall_o  = rst_ni & if_id_stall;
  assign hz.id_ex_bubble_o = rst_ni & bubble;
  assign hz.if_id_flush_o  = rst_ni & if_id_flush;
  assign hz.id_ex_flush_o  = rst_ni & id_ex_flush;
  assign hz.ex_stall_o     = rst_ni & ex_stall;
  assign hz.state_o        = rst_ni ? state_q : IDLE;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk_i   (clk_i),
    .clear_i (!rst_ni),
    .en_i    (hz.pc_stall_o),
    .count_o (stall_cycles_o)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed + random checks of hazard_unit against a
// cycle-level reference model of the stall/flush rules.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  hazard_unit_if hz_if ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hz     (hz_if)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // model: 0 = normal, 1 = waiting on multicycle op, 2 = flush shadow
  int          m_mode = 0;
  logic [31:0] m_cnt  = '0;

  task automatic clear_in();
    hz_if.id_rs1_i          = '0;
    hz_if.id_rs2_i          = '0;
    hz_if.id_uses_rs1_i     = 1'b0;
    hz_if.id_uses_rs2_i     = 1'b0;
    hz_if.ex_mem_read_i     = 1'b0;
    hz_if.ex_rd_i           = '0;
    hz_if.ex_branch_taken_i = 1'b0;
    hz_if.ex_mc_start_i     = 1'b0;
    hz_if.ex_mc_done_i      = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    hz_if.ex_mem_read_i = 1'b1;
    hz_if.ex_rd_i       = rd;
    hz_if.id_rs2_i      = rd;
    hz_if.id_uses_rs2_i = 1'b1;
  endtask

  // {pc_stall, if_id_stall, bubble, if_flush, id_flush, ex_stall, state}
  function automatic logic [7:0] model(output int nxt);
    logic lu;
    logic [7:0] e;
    int rd;
    rd = int'(hz_if.ex_rd_i);
    lu = hz_if.ex_mem_read_i && rd != 0 &&
         ((hz_if.id_uses_rs1_i && rd == int'(hz_if.id_rs1_i)) ||
          (hz_if.id_uses_rs2_i && rd == int'(hz_if.id_rs2_i)));
    e = 8'h00;
    nxt = 0;
    if (!rst_n) return e;
    if (m_mode == 1) begin
      e[1:0] = 2'b01;
      if (!hz_if.ex_mc_done_i) begin
        e[7:6] = 2'b11;
        e[2]   = 1'b1;
        nxt    = 1;
      end
    end else if (m_mode == 2) begin
      e[1:0] = 2'b10;
    end else if (hz_if.ex_branch_taken_i) begin
      e[4:3] = 2'b11;
      nxt    = 2;
    end else if (hz_if.ex_mc_start_i && !hz_if.ex_mc_done_i) begin
      e[7:6] = 2'b11;
      e[2]   = 1'b1;
      nxt    = 1;
    end else if (lu) begin
      e[7:5] = 3'b111;
    end
    return e;
  endfunction

  task automatic cyc(input string tag);
    logic [7:0] exp_v;
    logic [7:0] obs_v;
    int nxt;
    #2;
    exp_v = model(nxt);
    obs_v = {hz_if.pc_stall_o, hz_if.if_id_stall_o,
             hz_if.id_ex_bubble_o, hz_if.if_id_flush_o,
             hz_if.id_ex_flush_o, hz_if.ex_stall_o,
             hz_if.state_o};
    n_total++;
    assert (obs_v === exp_v) n_pass++;
    else $error("FAIL %s obs=%b exp=%b", tag, obs_v, exp_v);
`ifdef HAZARD_PERF_CNT_EN
    n_total++;
    assert (stall_cnt === m_cnt) n_pass++;
    else $error("FAIL %s_cnt obs=%0d exp=%0d", tag, stall_cnt, m_cnt);
`endif
    @(posedge clk);
    if (!rst_n) m_cnt = '0;
    else if (exp_v[7] && m_cnt != '1) m_cnt = m_cnt + 32'd1;
    m_mode = nxt;
    #1;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    // reset dominates any input pattern
    set_lu(5'd3);
    hz_if.ex_branch_taken_i = 1'b1;
    hz_if.ex_mc_start_i     = 1'b1;
    cyc("reset_hold");
    clear_in();
    rst_n = 1'b1;
    cyc("reset_idle");

    // single load-use stall on rs2
    set_lu(5'd5);
    cyc("lu_rs2");
    clear_in();
    cyc("lu_after");

    // x0 and unused source never stall
    hz_if.ex_mem_read_i = 1'b1;
    hz_if.id_uses_rs1_i = 1'b1;
    cyc("lu_x0");
    hz_if.ex_rd_i       = 5'd7;
    hz_if.id_rs1_i      = 5'd7;
    hz_if.id_uses_rs1_i = 1'b0;
    cyc("lu_unused");
    clear_in();

    // branch overrides load-use, then flush shadow
    set_lu(5'd9);
    hz_if.ex_branch_taken_i = 1'b1;
    cyc("br_lu");
    hz_if.ex_branch_taken_i = 1'b0;
    cyc("flush_shadow");
    clear_in();
    cyc("flush_idle");

    // multicycle op, done at cycle 4, branch at 2 ignored
    hz_if.ex_mc_start_i = 1'b1;
    cyc("mc_c0");
    clear_in();
    cyc("mc_c1");
    hz_if.ex_branch_taken_i = 1'b1;
    set_lu(5'd4);
    cyc("mc_c2_br");
    clear_in();
    cyc("mc_c3");
    hz_if.ex_mc_done_i = 1'b1;
    cyc("mc_c4_done");
    clear_in();
    cyc("mc_c5");

    // start and done together: single-cycle op
    hz_if.ex_mc_start_i = 1'b1;
    hz_if.ex_mc_done_i  = 1'b1;
    cyc("mc_same");
    clear_in();
    cyc("mc_same_nxt");

    // reset in the middle of a multicycle op
    hz_if.ex_mc_start_i = 1'b1;
    cyc("mr_c0");
    clear_in();
    cyc("mr_c1");
    rst_n = 1'b0;
    cyc("mr_rst");
    rst_n = 1'b1;
    cyc("mr_post0");
    cyc("mr_post1");

    // random traffic, small register range to hit matches
    for (int i = 0; i < 400; i++) begin
      hz_if.id_rs1_i          = 5'($urandom_range(0, 3));
      hz_if.id_rs2_i          = 5'($urandom_range(0, 3));
      hz_if.ex_rd_i           = 5'($urandom_range(0, 3));
      hz_if.id_uses_rs1_i     = 1'($urandom_range(0, 1));
      hz_if.id_uses_rs2_i     = 1'($urandom_range(0, 1));
      hz_if.ex_mem_read_i     = 1'($urandom_range(0, 1));
      hz_if.ex_branch_taken_i = ($urandom_range(0, 7) == 0);
      hz_if.ex_mc_start_i     = ($urandom_range(0, 5) == 0);
      hz_if.ex_mc_done_i      = ($urandom_range(0, 3) == 0);
      rst_n                   = ($urandom_range(0, 39) != 0);
      cyc("rand");
    end
    clear_in();
    rst_n = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
    rst_n = 1'b0;
    cyc("pc_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_lu(5'd6);
      cyc("pc_lu");
      clear_in();
      cyc("pc_gap");
    end
    hz_if.ex_mc_start_i = 1'b1;
    cyc("pc_mc0");
    clear_in();
    cyc("pc_mc1");
    cyc("pc_mc2");
    cyc("pc_mc3");
    hz_if.ex_mc_done_i = 1'b1;
    cyc("pc_done");
    clear_in();
    #2;
    n_total++;
    assert (stall_cnt === 32'd7) n_pass++;
    else $error("FAIL pc_seven obs=%0d exp=7", stall_cnt);
    #1;
    force dut.u_perf.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      set_lu(5'd2);
      cyc("pc_sat");
    end
    clear_in();
    #2;
    n_total++;
    assert (stall_cnt === 32'hFFFF_FFFF) n_pass++;
    else $error("FAIL pc_sat_end obs=%h exp=ffffffff", stall_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL provide clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL provide rst_ni  input  1  reset; synchronous, active-low.
REQ-003 SHALL provide id_rs1_i, id_rs2_i  input  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL provide id_uses_rs1_i, id_uses_rs2_i  input  1 each  ID instruction reads rs1/rs2.
REQ-005 SHALL provide ex_mem_read_i  input  1  instruction in EX is a load.
REQ-006 SHALL provide ex_rd_i  input  5  destination register of the instruction in EX.
REQ-007 SHALL provide ex_branch_taken_i  input  1  branch/jump resolved taken in EX this cycle.
REQ-008 SHALL provide ex_mc_start_i, ex_mc_done_i  input  1 each  multicycle EX op (mul/div) starts / delivers its result.
REQ-009 SHALL provide pc_stall_o, if_id_stall_o  output  1 each  hold PC and the IF/ID register.
REQ-010 SHALL provide id_ex_bubble_o  output  1  load a NOP into ID/EX.
REQ-011 SHALL provide if_id_flush_o, id_ex_flush_o  output  1 each  squash the IF/ID and ID/EX contents.
REQ-012 SHALL provide ex_stall_o  output  1  hold ID/EX and EX/MEM while a multicycle op runs.
REQ-013 SHALL provide state_o  output  2  current FSM state, for debug.

Function
REQ-014 SHALL implement the FSM states IDLE=2'b00, MC_BUSY=2'b01 and FLUSH=2'b10.
REQ-015 In IDLE, load-use SHALL be detected when ex_mem_read_i=1, ex_rd_i!=0, and either (id_uses_rs1_i and ex_rd_i==id_rs1_i) or (id_uses_rs2_i and ex_rd_i==id_rs2_i).
REQ-016 On a load-use detect, pc_stall_o, if_id_stall_o and id_ex_bubble_o SHALL be 1 in the same cycle (combinational), giving exactly one stall cycle with no state change.
REQ-017 In IDLE with ex_branch_taken_i=1, if_id_flush_o and id_ex_flush_o SHALL be 1 in the same cycle and the FSM SHALL enter FLUSH.
REQ-018 A taken branch SHALL override load-use in the same cycle: no stall and no bubble.
REQ-019 In FLUSH, all outputs SHALL be 0 and load-use detection SHALL be suppressed; the FSM SHALL return to IDLE after 1 cycle.
REQ-020 In IDLE with ex_mc_start_i=1 and no taken branch, the FSM SHALL enter MC_BUSY.
REQ-021 In the start cycle, pc_stall_o, if_id_stall_o and ex_stall_o SHALL already be 1.
REQ-022 In MC_BUSY, pc_stall_o, if_id_stall_o and ex_stall_o SHALL be 1 while ex_mc_done_i=0.
REQ-023 In MC_BUSY with ex_mc_done_i=1, all stall outputs SHALL be 0 in that cycle and the FSM SHALL return to IDLE.
REQ-024 In MC_BUSY, ex_branch_taken_i and load-use SHALL be ignored.
REQ-025 If ex_mc_start_i and ex_mc_done_i are both 1 in IDLE, the op SHALL be treated as single-cycle: no stall, and the FSM SHALL stay in IDLE.
REQ-026 Register x0 SHALL never cause a hazard.

Reset
REQ-027 While rst_ni=0 at a clock edge, state SHALL become IDLE.
REQ-028 During reset all outputs SHALL be 0, regardless of the inputs.
REQ-029 A reset in MC_BUSY or FLUSH SHALL abort the operation, with no residual stall after rst_ni returns to 1.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN SHALL control the performance counter.
REQ-031 With HAZARD_PERF_CNT_EN defined, the block SHALL add output stall_cycles_o (32 bits), which:
- increments on every cycle with pc_stall_o=1;
- saturates at 32'hFFFF_FFFF;
- clears on reset.
REQ-032 Without HAZARD_PERF_CNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 The hazard_state_t enum and the REG_ZERO=5'd0 constant SHALL live in the shared package riscv_pkg.
REQ-034 The performance counter SHALL be the single sub-module hazard_perf_cnt (en, clear, saturating count), instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-035 Load-use: ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5, id_uses_rs2_i=1 -> pc_stall_o, if_id_stall_o and id_ex_bubble_o are 1 for exactly 1 cycle; state_o stays 00.
REQ-036 x0 / unused source: ex_rd_i=0 with a matching rs, or a match with id_uses_rs1_i=0 -> all outputs 0.
REQ-037 Branch vs load-use: a taken branch in the same cycle as a load-use match -> both flush outputs are 1 and no stall; next cycle state_o=10 with outputs 0; then IDLE.
REQ-038 Multicycle: ex_mc_start_i at cycle 0, ex_mc_done_i at cycle 4 -> ex_stall_o=1 in cycles 0-3 and 0 in cycle 4; state_o=00 at cycle 5; a taken branch at cycle 2 is ignored.
REQ-039 Reset mid-op: rst_ni=0 at cycle 2 of MC_BUSY -> state_o=00 and all outputs 0 after the edge, and they stay 0 after release.
REQ-040 Perf counter (macro defined): 3 load-use stalls plus a 4-cycle MC_BUSY -> stall_cycles_o=7; a preloaded all-ones value stays all-ones.
